// File: rtl/clint_pkg.sv
// Shared CLINT constants: CSR addresses, system instruction encodings, trap causes
// and the interrupt FSM state encoding.
package clint_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int CAUSE_IRQ_BASE = 16;
  localparam int CAUSE_ECALL    = 11;
  localparam int CAUSE_EBREAK   = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEPC     = 3'd1,
    MSTATUS  = 3'd2,
    MCAUSE   = 3'd3,
    REDIRECT = 3'd4,
    MRET     = 3'd5
  } clint_state_e;

endpackage

// File: rtl/clint_irq_prio_enc.sv
// Lowest-set-bit priority encoder for the external interrupt lines.
// Purely combinational: index of the lowest asserted request plus a valid flag.
module irq_prio_enc #(
  parameter int IRQ_W = 8,
  parameter int IDX_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1
) (
  input  logic [IRQ_W-1:0] irq_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan high to low so the lowest set bit is the last assignment that sticks.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (irq_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interrupt controller: sequences trap entry / mret CSR writes and PC redirect.
// ecall/ebreak are decoded as synchronous traps only when CLINT_SYNC_EXC_EN is defined.
module clint
  import clint_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [XLEN-1:0]  int_addr_o
);

  localparam int IDX_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;

  clint_state_e    state_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] ret_pc_d, cause_d;
  logic            irq_vld;
  logic [IDX_W-1:0] irq_idx;
  logic            is_mret, is_ecall, is_ebreak, take_sync, take_async;

  irq_prio_enc #(.IRQ_W(IRQ_W), .IDX_W(IDX_W)) u_irq_prio_enc (
    .irq_i (irq_i),
    .idx_o (irq_idx),
    .vld_o (irq_vld)
  );

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  always_comb begin
    is_mret = (inst_i == INST_MRET);
`ifdef CLINT_SYNC_EXC_EN
    is_ecall  = (inst_i == INST_ECALL);
    is_ebreak = (inst_i == INST_EBREAK);
`else
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
`endif
    // Synchronous events win over a coincident interrupt.
    take_sync  = (state_q == IDLE) && (is_mret || is_ecall || is_ebreak);
    take_async = (state_q == IDLE) && !take_sync && irq_vld && csr_mstatus_i[3];

    if (jump_flag_i)     ret_pc_d = jump_addr_i;
    else if (take_async) ret_pc_d = inst_addr_i;
    else                 ret_pc_d = inst_addr_i + XLEN'(4);

    if (take_async)    cause_d = {1'b1, (XLEN-1)'(CAUSE_IRQ_BASE + int'(irq_idx))};
    else if (is_ecall) cause_d = XLEN'(CAUSE_ECALL);
    else               cause_d = XLEN'(CAUSE_EBREAK);
  end

  assign hold_flag_o = !rst && ((state_q != IDLE) || take_sync || take_async);

  // Outputs are registered one state ahead so each CSR write is presented during its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state_q)
        IDLE: begin
          if (take_sync && is_mret) begin
            state_q     <= MRET;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MSTATUS;
            csr_wdata_o <= mstatus_on_mret(csr_mstatus_i);
          end else if (take_sync || take_async) begin
            state_q     <= MEPC;
            cause_q     <= cause_d;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MEPC;
            csr_wdata_o <= ret_pc_d;
          end
        end
        MEPC: begin
          state_q     <= MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MSTATUS;
          csr_wdata_o <= mstatus_on_trap(csr_mstatus_i);
        end
        MSTATUS: begin
          state_q     <= MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MCAUSE;
          csr_wdata_o <= cause_q;
        end
        MCAUSE: begin
          state_q      <= REDIRECT;
          int_assert_o <= 1'b1;
          int_addr_o   <= {csr_mtvec_i[XLEN-1:2], 2'b00};
        end
        MRET: begin
          state_q      <= REDIRECT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: trap entry, jump return PC, mret, sync/async priority,
// masked interrupts and asynchronous reset mid-sequence.
module tb_clint;

  localparam int XLEN  = 32;
  localparam int IRQ_W = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IRQ_W-1:0] irq_i = '0;
  logic [31:0]      inst_i = NOP;
  logic [XLEN-1:0]  inst_addr_i = '0;
  logic             jump_flag_i = 1'b0;
  logic [XLEN-1:0]  jump_addr_i = '0;
  logic [XLEN-1:0]  csr_mtvec_i = '0;
  logic [XLEN-1:0]  csr_mepc_i = '0;
  logic [XLEN-1:0]  csr_mstatus_i = '0;
  logic             csr_we_o;
  logic [11:0]      csr_waddr_o;
  logic [XLEN-1:0]  csr_wdata_o;
  logic             hold_flag_o;
  logic             int_assert_o;
  logic [XLEN-1:0]  int_addr_o;

  int tests = 0;
  int fails = 0;

  clint #(.XLEN(XLEN), .IRQ_W(IRQ_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq_i),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .hold_flag_o   (hold_flag_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] data);
    check({tag, "_we"}, 64'(csr_we_o), 64'd1);
    check({tag, "_addr"}, 64'(csr_waddr_o), 64'(addr));
    check({tag, "_data"}, 64'(csr_wdata_o), 64'(data));
    check({tag, "_hold"}, 64'(hold_flag_o), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, 64'(csr_we_o), 64'd0);
    check({tag, "_waddr"}, 64'(csr_waddr_o), 64'd0);
    check({tag, "_wdata"}, 64'(csr_wdata_o), 64'd0);
    check({tag, "_int"}, 64'(int_assert_o), 64'd0);
    check({tag, "_hold"}, 64'(hold_flag_o), 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_quiet("reset");
    check("reset_addr", 64'(int_addr_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Async interrupt: irq bit 2 at PC 0x40, first clock after reset release
    csr_mtvec_i   = 32'h0000_0101;
    csr_mstatus_i = 32'h0000_0008;
    inst_addr_i   = 32'h40;
    irq_i         = 8'h04;
    #1;
    check("irq_accept_hold", 64'(hold_flag_o), 64'd1);
    check("irq_accept_we", 64'(csr_we_o), 64'd0);
    tick();
    check_csr("irq_mepc", 12'h341, 32'h40);
    irq_i = 8'h01;
    tick();
    check_csr("irq_mstatus", 12'h300, 32'h80);
    tick();
    check_csr("irq_mcause", 12'h342, 32'h8000_0012);
    tick();
    check("irq_redir_we", 64'(csr_we_o), 64'd0);
    check("irq_redir_int", 64'(int_assert_o), 64'd1);
    check("irq_redir_addr", 64'(int_addr_o), 64'h100);
    check("irq_redir_hold", 64'(hold_flag_o), 64'd1);
    irq_i = 8'h00;
    tick();
    check_quiet("irq_done");

    // Jump resolved in the accepting cycle supplies the return PC
    irq_i       = 8'h04;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h80;
    tick();
    check_csr("jump_mepc", 12'h341, 32'h80);
    jump_flag_i = 1'b0;
    irq_i       = 8'h00;
    tick();
    tick();
    tick();
    tick();
    check_quiet("jump_done");

    // mret: mstatus 0x80 -> 0x88, redirect to mepc, 3 cycles of hold
    csr_mepc_i    = 32'h44;
    csr_mstatus_i = 32'h80;
    inst_i        = 32'h3020_0073;
    #1;
    check("mret_accept_hold", 64'(hold_flag_o), 64'd1);
    tick();
    check_csr("mret_mstatus", 12'h300, 32'h88);
    inst_i = NOP;
    tick();
    check("mret_redir_we", 64'(csr_we_o), 64'd0);
    check("mret_redir_int", 64'(int_assert_o), 64'd1);
    check("mret_redir_addr", 64'(int_addr_o), 64'h44);
    check("mret_redir_hold", 64'(hold_flag_o), 64'd1);
    tick();
    check_quiet("mret_done");

    // ecall at 0x60 coinciding with irq bit 0
    csr_mstatus_i = 32'h08;
    inst_addr_i   = 32'h60;
    inst_i        = 32'h0000_0073;
    irq_i         = 8'h01;
    tick();
    inst_i = NOP;
    irq_i  = 8'h00;
`ifdef CLINT_SYNC_EXC_EN
    check_csr("ecall_mepc", 12'h341, 32'h64);
    tick();
    tick();
    check_csr("ecall_mcause", 12'h342, 32'd11);
`else
    check_csr("ecall_mepc", 12'h341, 32'h60);
    tick();
    tick();
    check_csr("ecall_mcause", 12'h342, 32'h8000_0010);
`endif
    tick();
    tick();
    check_quiet("ecall_done");

    // Interrupts masked: no hold, no writes
    csr_mstatus_i = 32'h00;
    irq_i         = 8'hFF;
    #1;
    check("masked_hold_comb", 64'(hold_flag_o), 64'd0);
    tick();
    check_quiet("masked_c1");
    tick();
    check_quiet("masked_c2");

    // Reset asserted while in MSTATUS clears outputs without a clock
    csr_mstatus_i = 32'h08;
    irq_i         = 8'h04;
    tick();
    tick();
    check_csr("rst_pre_mstatus", 12'h300, 32'h80);
    irq_i = 8'h00;
    #1;
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    check("rst_async_addr", 64'(int_addr_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_quiet("rst_idle_c1");
    tick();
    check_quiet("rst_idle_c2");
    tick();
    check_quiet("rst_idle_c3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/address width.
REQ-002 SHALL have parameter IRQ_W, default 8: external interrupt lines.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port irq_i  input  IRQ_W: level-sensitive external interrupt requests.
REQ-006 SHALL have port inst_i  input  32: instruction currently in decode.
REQ-007 SHALL have port inst_addr_i  input  XLEN: PC of inst_i.
REQ-008 SHALL have ports jump_flag_i  input  1 and jump_addr_i  input  XLEN: branch or jump resolved in ex this cycle.
REQ-009 SHALL have ports csr_mtvec_i, csr_mepc_i, csr_mstatus_i  input  XLEN: current CSR values.
REQ-010 SHALL have ports csr_we_o  output  1, csr_waddr_o  output  12, csr_wdata_o  output  XLEN: CSR write port.
REQ-011 SHALL have port hold_flag_o  output  1: stall request into the pipeline controller's interrupt hold input.
REQ-012 SHALL have ports int_assert_o  output  1 and int_addr_o  output  XLEN: one-cycle redirect of PC.

Function
REQ-013 SHALL implement FSM states IDLE, MEPC, MSTATUS, MCAUSE, REDIRECT, MRET.
REQ-014 SHALL take an async interrupt in IDLE when |irq_i and mstatus[3] (MIE) is 1.
REQ-015 SHALL decode mret (0x30200073) in IDLE as a return event.
REQ-016 SHALL give sync events (mret, ecall, ebreak) priority over async interrupts when both occur in the same cycle.
REQ-017 SHALL drive hold_flag_o combinationally high whenever state != IDLE, or when an event is accepted in IDLE.
REQ-018 SHALL latch the return PC at acceptance:
  - jump_addr_i if jump_flag_i is 1;
  - otherwise inst_addr_i for an async interrupt;
  - otherwise inst_addr_i + 4 for ecall/ebreak.
REQ-019 SHALL latch the cause at acceptance:
  - async: {1'b1, 16 + index of lowest set irq_i bit};
  - ecall: 11;
  - ebreak: 3.
REQ-020 SHALL run the trap sequence IDLE->MEPC->MSTATUS->MCAUSE->REDIRECT->IDLE, with one CSR write per state:
  - MEPC: csr 0x341 <= return PC;
  - MSTATUS: csr 0x300 <= mstatus with MPIE[7] = MIE[3] and MIE[3] = 0;
  - MCAUSE: csr 0x342 <= cause.
REQ-021 SHALL, in REDIRECT, pulse int_assert_o for exactly one cycle with int_addr_o = csr_mtvec_i & ~3.
REQ-022 SHALL run the return sequence IDLE->MRET->REDIRECT->IDLE:
  - MRET: csr 0x300 <= mstatus with MIE = MPIE and MPIE = 1;
  - REDIRECT: int_addr_o = csr_mepc_i.
REQ-023 SHALL give a trap 5 cycles of hold and a return 3 cycles of hold, measured from acceptance to return to IDLE.
REQ-024 SHALL ignore irq_i and inst_i while not in IDLE; irq changes during a sequence do not alter the latched cause.
REQ-025 SHALL keep csr_we_o at 0 in IDLE and REDIRECT, and keep csr_waddr_o/csr_wdata_o at 0 when csr_we_o is 0.
REQ-026 SHALL not re-enter on the same level interrupt, because MIE = 0 after the trap; firmware clears the source.

Reset
REQ-027 SHALL, on rst assertion at any time (including mid-sequence), force state = IDLE and all outputs plus latched PC/cause to 0, without waiting for a clock.
REQ-028 SHALL begin event acceptance in the first clock after rst deasserts.

Configuration
REQ-029 SHALL use macro CLINT_SYNC_EXC_EN to control ecall/ebreak handling:
  - defined: ecall (0x00000073) and ebreak (0x00100073) are decoded as sync traps per REQ-018/019;
  - undefined: ecall/ebreak are not decoded and pass as ordinary instructions, and mret and async interrupts are unchanged.

Structure
REQ-030 SHALL place the following in the shared parameter header used by the CPU:
  - CSR addresses (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MTVEC 0x305);
  - instruction encodings for ecall/ebreak/mret;
  - the FSM state encoding.
REQ-031 SHALL implement lowest-set-bit IRQ priority as sub-module irq_prio_enc (IRQ_W in, index plus valid out).

Verification
REQ-032 SHALL cover: mtvec = 0x100, MIE = 1, irq_i = 0x04 at inst_addr 0x40 -> mepc = 0x40, mcause = 0x80000012, MIE = 0/MPIE = 1, int_assert one cycle with addr 0x100, hold high 5 cycles.
REQ-033 SHALL cover: irq_i = 0x04 with jump_flag_i = 1, jump_addr 0x80 -> mepc = 0x80.
REQ-034 SHALL cover: mret with mepc = 0x44, mstatus = 0x80 -> mstatus write 0x88, int_addr = 0x44, hold 3 cycles.
REQ-035 SHALL cover: ecall at 0x60 plus irq_i = 0x01 in the same cycle, macro defined -> mcause = 11, mepc = 0x64; macro undefined -> interrupt taken, mcause = 0x80000010.
REQ-036 SHALL cover: MIE = 0 with irq_i = 0xFF -> no hold, no CSR writes.
REQ-037 SHALL cover: rst asserted in MSTATUS -> outputs 0 immediately; after release with irq_i = 0, FSM stays in IDLE.
